// File: rtl/m_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : m_alu_exec_unit
// Purpose  : Execute-stage ALU. Decodes the 3-bit alucontrol code and
//            produces a registered result. AND/OR/ADD/SUB/SLT complete in one
//            registered cycle. MUL runs on an iterative shift-add engine for
//            WIDTH cycles while busy is raised so the pipeline can stall.
// Ports    : clk, rst_n       - clock, asynchronous active-low reset
//            in_valid/in_ready - input handshake (ready only in IDLE)
//            alucontrol       - 000 and, 001 or, 010 add, 011 mul,
//                               110 sub, 111 slt, 100/101 illegal
//            srca, srcb       - operands
//            flush            - synchronous abort of accepted/in-flight op
//            out_valid        - one-cycle result pulse
//            aluout, zero     - registered result and (aluout == 0)
//            illegal          - pulses with out_valid for codes 100/101
//            busy             - high while the multiply iterates
// Revision : 1.0 - initial release
// ============================================================================
module m_alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] aluout,
  output logic             zero,
  output logic             illegal,
  output logic             busy
);

  localparam int         CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [2:0] C_OP_AND = 3'b000;
  localparam logic [2:0] C_OP_OR  = 3'b001;
  localparam logic [2:0] C_OP_ADD = 3'b010;
  localparam logic [2:0] C_OP_MUL = 3'b011;
  localparam logic [2:0] C_OP_SUB = 3'b110;
  localparam logic [2:0] C_OP_SLT = 3'b111;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] aluout_q, aluout_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_illegal;
  logic [WIDTH-1:0] acc_sum;

  // Single-cycle operations. Illegal codes resolve to a zero result.
  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (alucontrol)
      C_OP_AND: alu_res = srca & srcb;
      C_OP_OR:  alu_res = srca | srcb;
      C_OP_ADD: alu_res = srca + srcb;
      C_OP_SUB: alu_res = srca - srcb;
      C_OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      C_OP_MUL: alu_res = '0;
      default:  alu_illegal = 1'b1;
    endcase
  end

  // Accumulator value after the current shift-add step; on the last step
  // this is already the final product, so it is what lands in aluout.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d     = state_q;
    aluout_d    = aluout_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;
    illegal_d   = 1'b0;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;

    if (flush) begin
      // Abort wins over any accept; the visible result is left untouched.
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (alucontrol == C_OP_MUL) begin
              mcand_d  = srca;
              mplier_d = srcb;
              acc_d    = '0;
              cnt_d    = '0;
              state_d  = S_MUL;
            end else begin
              aluout_d    = alu_res;
              zero_d      = (alu_res == '0);
              illegal_d   = alu_illegal;
              out_valid_d = 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == C_LAST_CNT) begin
            aluout_d    = acc_sum;
            zero_d      = (acc_sum == '0);
            out_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      aluout_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      aluout_q    <= aluout_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_MUL);
  assign out_valid = out_valid_q;
  assign aluout    = aluout_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_m_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_m_alu_exec_unit
// Purpose  : Self-checking bench for m_alu_exec_unit: table of single-cycle
//            vectors applied back-to-back, then hand-written multiply, flush
//            and asynchronous-reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m_alu_exec_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alucontrol;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] aluout;
  logic             zero;
  logic             illegal;
  logic             busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        ez;
    logic        eill;
  } vec_t;

  vec_t vecs[13];

  m_alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alucontrol (alucontrol),
    .srca       (srca),
    .srcb       (srcb),
    .flush      (flush),
    .out_valid  (out_valid),
    .aluout     (aluout),
    .zero       (zero),
    .illegal    (illegal),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance through one rising edge and land on the following falling edge.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic v);
    alucontrol = op;
    srca       = a;
    srcb       = b;
    in_valid   = v;
  endtask

  // Multiply from E0 to E32; optionally holds an add (1+2) on the inputs
  // during the iteration, which must not be taken before E33.
  task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input logic [31:0] prev, input bit hold);
    int bad;
    bad = 0;
    drive(3'b011, a, b, 1'b1);
    tick;  // E0
    if (hold) drive(3'b010, 32'd1, 32'd2, 1'b1);
    else      drive(3'b000, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
    for (int k = 0; k < 32; k++) begin
      if (k > 0) tick;  // E1..E31
      if (!(busy === 1'b1 && in_ready === 1'b0 && out_valid === 1'b0 && aluout === prev))
        bad++;
    end
    chk({name, " busy window bad cycles"}, bad, 0);
    tick;  // E32
    chk({name, " out_valid@E32"}, {31'd0, out_valid}, 1);
    chk({name, " aluout@E32"}, aluout, exp);
    chk({name, " zero@E32"}, {31'd0, zero}, {31'd0, (exp == 32'd0)});
    chk({name, " busy@E32"}, {31'd0, busy}, 0);
    chk({name, " in_ready@E32"}, {31'd0, in_ready}, 1);
  endtask

  initial begin
    vecs[0]  = '{"add 5+7",        3'b010, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
    vecs[1]  = '{"sub 9-9",        3'b110, 32'd9,          32'd9,          32'd0,          1'b1, 1'b0};
    vecs[2]  = '{"slt -1<1",       3'b111, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0};
    vecs[3]  = '{"slt 1<-1",       3'b111, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0};
    vecs[4]  = '{"add wrap",       3'b010, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b0};
    vecs[5]  = '{"and",            3'b000, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0, 1'b0};
    vecs[6]  = '{"or",             3'b001, 32'h0F0F_0000,  32'h0000_00F0,  32'h0F0F_00F0,  1'b0, 1'b0};
    vecs[7]  = '{"sub 0-1",        3'b110, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1'b0};
    vecs[8]  = '{"illegal 100",    3'b100, 32'h1234_5678,  32'h9ABC_DEF0,  32'd0,          1'b1, 1'b1};
    vecs[9]  = '{"and after ill",  3'b000, 32'hFFFF_FFFF,  32'h1234_5678,  32'h1234_5678,  1'b0, 1'b0};
    vecs[10] = '{"illegal 101",    3'b101, 32'd3,          32'd4,          32'd0,          1'b1, 1'b1};
    vecs[11] = '{"slt min<max",    3'b111, 32'h8000_0000,  32'h7FFF_FFFF,  32'd1,          1'b0, 1'b0};
    vecs[12] = '{"slt 5<5",        3'b111, 32'd5,          32'd5,          32'd0,          1'b1, 1'b0};

    rst_n = 1'b1;
    flush = 1'b0;
    drive(3'b000, 32'd0, 32'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("reset aluout",    aluout, 0);
    chk("reset zero",      {31'd0, zero}, 1);
    chk("reset out_valid", {31'd0, out_valid}, 0);
    chk("reset illegal",   {31'd0, illegal}, 0);
    chk("reset busy",      {31'd0, busy}, 0);
    chk("reset in_ready",  {31'd0, in_ready}, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back single-cycle ops: in_valid stays high, one result per edge.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
      tick;
      chk({vecs[i].name, " out_valid"}, {31'd0, out_valid}, 1);
      chk({vecs[i].name, " aluout"},    aluout, vecs[i].exp);
      chk({vecs[i].name, " zero"},      {31'd0, zero}, {31'd0, vecs[i].ez});
      chk({vecs[i].name, " illegal"},   {31'd0, illegal}, {31'd0, vecs[i].eill});
      chk({vecs[i].name, " in_ready"},  {31'd0, in_ready}, 1);
    end
    in_valid = 1'b0;
    tick;
    chk("idle out_valid drop", {31'd0, out_valid}, 0);
    chk("idle aluout hold",    aluout, 0);

    // 7 * -3 with an add held on the inputs throughout the iteration.
    run_mul("mul 7x-3", 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32'd0, 1'b1);
    tick;  // E33: held add is taken here
    chk("held add out_valid@E33", {31'd0, out_valid}, 1);
    chk("held add aluout@E33",    aluout, 32'd3);
    in_valid = 1'b0;
    tick;
    chk("after held add out_valid", {31'd0, out_valid}, 0);

    // Flush at E10 of mul 100*200.
    drive(3'b011, 32'd100, 32'd200, 1'b1);
    tick;  // E0
    in_valid = 1'b0;
    repeat (9) tick;  // E1..E9
    flush = 1'b1;
    tick;  // E10
    chk("flush out_valid", {31'd0, out_valid}, 0);
    chk("flush aluout",    aluout, 32'd3);
    chk("flush in_ready",  {31'd0, in_ready}, 1);
    chk("flush busy",      {31'd0, busy}, 0);
    drive(3'b010, 32'd1, 32'd1, 1'b1);
    tick;  // flush with in_valid: nothing accepted
    chk("flush+add out_valid", {31'd0, out_valid}, 0);
    chk("flush+add aluout",    aluout, 32'd3);
    chk("flush+add busy",      {31'd0, busy}, 0);
    flush    = 1'b0;
    in_valid = 1'b0;
    begin
      int stray;
      stray = 0;
      for (int k = 0; k < 40; k++) begin
        tick;
        if (out_valid !== 1'b0) stray++;
      end
      chk("post-flush stray out_valid", stray, 0);
    end
    chk("post-flush aluout", aluout, 32'd3);

    // Asynchronous reset between edges while a multiply iterates.
    drive(3'b011, 32'd5, 32'd6, 1'b1);
    tick;  // E0
    in_valid = 1'b0;
    repeat (5) tick;
    #2 rst_n = 1'b0;
    #1;
    chk("async rst aluout",    aluout, 0);
    chk("async rst zero",      {31'd0, zero}, 1);
    chk("async rst out_valid", {31'd0, out_valid}, 0);
    chk("async rst illegal",   {31'd0, illegal}, 0);
    chk("async rst busy",      {31'd0, busy}, 0);
    chk("async rst in_ready",  {31'd0, in_ready}, 1);
    @(negedge clk);
    rst_n = 1'b1;

    run_mul("mul 3x4", 32'd3, 32'd4, 32'd12, 32'd0, 1'b0);
    tick;
    chk("mul 3x4 single pulse", {31'd0, out_valid}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
